// File: rtl/blob_arb_pkg.sv
// Shared types and helpers for the round-robin blob arbiter.
package blob_arb_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int idx, input int num_src);
    return (idx >= num_src - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/blob_rr_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping upward.
module rr_pick #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [NUM_SRC-1:0]   gnt,
  output logic [SRC_IDX_W-1:0] idx
);
  logic found;

  // Upper half [ptr..N-1] has priority over the wrapped half [0..ptr-1].
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = SRC_IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = SRC_IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/blob_rr_arb.sv
// Round-robin blob arbiter: 1-cycle grant, 0-cycle beat path; next grant waits for conv_dout_eop.
// Per-source blob counters are built only with BLOB_RR_ARB_STAT_EN defined.
module blob_rr_arb
  import blob_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int SRC_IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_din,
  output logic [NUM_SRC-1:0]            src_din_rdy,
  input  logic [NUM_SRC-1:0]            src_din_en,
  input  logic [NUM_SRC-1:0]            src_din_eop,
  output logic [DATA_WIDTH-1:0]         blob_din,
  input  logic                          blob_din_rdy,
  output logic                          blob_din_en,
  output logic                          blob_din_eop,
  input  logic                          conv_dout_eop,
  output logic [NUM_SRC-1:0]            grant,
  output logic [SRC_IDX_W-1:0]          grant_idx,
  output logic                          busy,
  output logic [NUM_SRC*STAT_W-1:0]     stat_blob_cnt
);
  state_t                 state_q, state_d;
  logic [NUM_SRC-1:0]     grant_q, grant_d;
  logic [SRC_IDX_W-1:0]   idx_q, idx_d;
  logic [SRC_IDX_W-1:0]   rr_ptr_q;
  logic [NUM_SRC-1:0]     pick_gnt;
  logic [SRC_IDX_W-1:0]   pick_idx;
  logic                   done;

  rr_pick #(.NUM_SRC(NUM_SRC), .SRC_IDX_W(SRC_IDX_W)) u_pick (
    .req (src_req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    done         = 1'b0;
    src_din_rdy  = '0;
    blob_din     = '0;
    blob_din_en  = 1'b0;
    blob_din_eop = 1'b0;
    case (state_q)
      IDLE: begin
        if (|src_req) begin
          grant_d = pick_gnt;
          idx_d   = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        blob_din     = src_din[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        src_din_rdy  = grant_q & {NUM_SRC{blob_din_rdy}};
        blob_din_en  = src_din_en[idx_q] & blob_din_rdy;
        blob_din_eop = src_din_eop[idx_q] & blob_din_en;
        // Converter may already report the blob out in the eop cycle.
        if (blob_din_eop) begin
          if (conv_dout_eop) done = 1'b1;
          else               state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (conv_dout_eop) done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      grant_d = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      if (done) rr_ptr_q <= SRC_IDX_W'(rr_next(int'(idx_q), NUM_SRC));
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q != IDLE);

`ifdef BLOB_RR_ARB_STAT_EN
  logic [NUM_SRC-1:0][STAT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else if (done) cnt_q[idx_q] <= cnt_q[idx_q] + STAT_W'(1);
  end

  assign stat_blob_cnt = cnt_q;
`else
  assign stat_blob_cnt = '0;
`endif
endmodule

// File: tb/tb_blob_rr_arb.sv
// Directed bench for blob_rr_arb with a beat scoreboard checked on the falling edge.
module tb_blob_rr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    src_req = '0;
  logic [N*DW-1:0] src_din = '0;
  logic [N-1:0]    src_din_rdy;
  logic [N-1:0]    src_din_en = '0;
  logic [N-1:0]    src_din_eop = '0;
  logic [DW-1:0]   blob_din;
  logic            blob_din_rdy = 1'b1;
  logic            blob_din_en;
  logic            blob_din_eop;
  logic            conv_dout_eop = 1'b0;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_idx;
  logic            busy;
  logic [N*16-1:0] stat_blob_cnt;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          eop;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;

  blob_rr_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .SRC_IDX_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .src_req       (src_req),
    .src_din       (src_din),
    .src_din_rdy   (src_din_rdy),
    .src_din_en    (src_din_en),
    .src_din_eop   (src_din_eop),
    .blob_din      (blob_din),
    .blob_din_rdy  (blob_din_rdy),
    .blob_din_en   (blob_din_en),
    .blob_din_eop  (blob_din_eop),
    .conv_dout_eop (conv_dout_eop),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .stat_blob_cnt (stat_blob_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every converter strobe must match the oldest outstanding expected beat.
  always @(negedge clk) begin
    if (blob_din_en === 1'b1) begin
      beats_seen++;
      chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", 64'(blob_din), 64'(e.d));
        chk("beat_eop", 64'(blob_din_eop), 64'(e.eop));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int g, input logic [DW-1:0] d, input logic eop);
    src_din[g*DW +: DW] = d;
    src_din_en[g]       = 1'b1;
    src_din_eop[g]      = eop;
    exp_q.push_back('{d: d, eop: eop});
  endtask

  task automatic idle_src();
    src_din_en  = '0;
    src_din_eop = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'(0));
    chk({tag, "_grant_idx"}, 64'(grant_idx), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_src_rdy"}, 64'(src_din_rdy), 64'(0));
    chk({tag, "_blob_en"}, 64'(blob_din_en), 64'(0));
    chk({tag, "_blob_eop"}, 64'(blob_din_eop), 64'(0));
    chk({tag, "_blob_din"}, 64'(blob_din), 64'(0));
    chk({tag, "_stat"}, 64'(stat_blob_cnt), 64'(0));
  endtask

  initial begin
    logic [3:0]  pat;
    logic [63:0] exp_stat;
    int          b;

    // Reset state
    cyc(); cyc();
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Single source, 3-beat blob
    src_req = 4'b0001;
    #1;
    chk("single_no_grant_yet", 64'(grant), 64'(0));
    cyc();
    chk("single_grant", 64'(grant), 64'(4'b0001));
    chk("single_busy", 64'(busy), 64'(1));
    src_req = '0;
    send(0, 32'hA0, 1'b0);
    #1;
    chk("single_src_rdy", 64'(src_din_rdy), 64'(4'b0001));
    chk("single_en", 64'(blob_din_en), 64'(1));
    chk("single_eop_lo", 64'(blob_din_eop), 64'(0));
    cyc(); send(0, 32'hA1, 1'b0);
    cyc(); send(0, 32'hA2, 1'b1);
    #1;
    chk("single_eop_hi", 64'(blob_din_eop), 64'(1));
    cyc(); idle_src();
    #1;
    chk("drain_busy", 64'(busy), 64'(1));
    chk("drain_en", 64'(blob_din_en), 64'(0));
    chk("drain_rdy", 64'(src_din_rdy), 64'(0));
    chk("single_beats", 64'(beats_seen), 64'(3));
    conv_dout_eop = 1'b1;
    cyc(); conv_dout_eop = 1'b0;
    chk("single_busy_after", 64'(busy), 64'(0));
    chk("single_grant_after", 64'(grant), 64'(0));

    // All request, 1-beat blobs, from a fresh pointer
    rst = 1'b0; cyc(); rst = 1'b1;
    src_req = '1;
    cyc();
    for (int n = 0; n < 5; n++) begin
      chk("rr_idx", 64'(grant_idx), 64'(n % 4));
      chk("rr_grant", 64'(grant), 64'(1) << (n % 4));
      send(n % 4, 32'hB0 + 32'(n), 1'b1);
      cyc(); idle_src();
      conv_dout_eop = 1'b1;
      #1;
      chk("rr_drain_busy", 64'(busy), 64'(1));
      cyc(); conv_dout_eop = 1'b0;
      if (n == 4) src_req = '0;
      chk("rr_gap_grant", 64'(grant), 64'(0));
      cyc();
    end

    // Backpressure on source 1 (pointer now at 1)
    src_req = 4'b0010;
    cyc(); src_req = '0;
    chk("bp_grant", 64'(grant), 64'(4'b0010));
    pat = 4'b1101;
    b = 0;
    for (int s = 0; s < 4; s++) begin
      idle_src();
      blob_din_rdy = pat[s];
      #1;
      chk("bp_src_rdy", 64'(src_din_rdy), pat[s] ? 64'(4'b0010) : 64'(0));
      if (src_din_rdy[1]) begin
        send(1, 32'hC0 + 32'(b), b == 2);
        b++;
      end
      #1;
      chk("bp_en", 64'(blob_din_en), 64'(pat[s]));
      cyc();
    end
    idle_src();
    blob_din_rdy = 1'b1;
    chk("bp_drain_busy", 64'(busy), 64'(1));
    conv_dout_eop = 1'b1;
    cyc(); conv_dout_eop = 1'b0;
    chk("bp_idle", 64'(busy), 64'(0));

    // Stray strobes from source 2 while source 0 owns the bus
    src_req = 4'b0001;
    cyc(); src_req = '0;
    chk("stray_grant", 64'(grant), 64'(4'b0001));
    src_din[2*DW +: DW] = 32'hDEAD;
    src_din_en[2]       = 1'b1;
    src_din_eop[2]      = 1'b1;
    #1;
    chk("stray_en", 64'(blob_din_en), 64'(0));
    chk("stray_rdy2", 64'(src_din_rdy[2]), 64'(0));
    cyc();
    chk("stray_still_xfer", 64'(busy), 64'(1));

    // eop beat and conv_dout_eop together
    send(0, 32'hE0, 1'b1);
    conv_dout_eop = 1'b1;
    #1;
    chk("simul_eop", 64'(blob_din_eop), 64'(1));
    cyc(); conv_dout_eop = 1'b0; idle_src();
    chk("simul_idle", 64'(busy), 64'(0));
    chk("simul_grant_clr", 64'(grant), 64'(0));
    src_req = '1;
    cyc(); src_req = '0;
    chk("simul_ptr_adv", 64'(grant_idx), 64'(1));

    // Reset in the middle of a transfer
    send(1, 32'hF0, 1'b0);
    #1;
    chk("midrst_en_before", 64'(blob_din_en), 64'(1));
    rst = 1'b0;
    cyc();
    chk_reset_outputs("midrst");
    rst = 1'b1;
    idle_src();

    // Five blobs from source 1
    src_req = 4'b0010;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("stat_grant", 64'(grant), 64'(4'b0010));
      send(1, 32'h100 + 32'(k), 1'b1);
      conv_dout_eop = 1'b1;
      cyc(); conv_dout_eop = 1'b0; idle_src();
      if (k == 4) src_req = '0;
      chk("stat_idle", 64'(busy), 64'(0));
      cyc();
    end
`ifdef BLOB_RR_ARB_STAT_EN
    exp_stat = 64'd5 << 16;
`else
    exp_stat = 64'd0;
`endif
    chk("stat_cnt", 64'(stat_blob_cnt), exp_stat);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
